// File: rtl/note_scheduler.sv
// Chart sequencer and per-lane judge for the rhythm-game LED lanes: scroll tick,
// chart playback from a 1-cycle-latency ROM, note shadow, hit/near/miss grading.
module note_scheduler #(
   parameter int LANES    = 4,
   parameter int SLOTS    = 8,
   parameter int TICK_DIV = 512,
   parameter int ADDR_W   = 8,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start_i,
   input  logic [LANES-1:0]  key_i,
   output logic [ADDR_W-1:0] chart_addr_o,
   input  logic [LANES:0]    chart_data_i,
   output logic              tick_o,
   output logic [LANES-1:0]  spawn_o,
   output logic [LANES-1:0]  hit_o,
   output logic [LANES-1:0]  near_o,
   output logic [LANES-1:0]  miss_o,
   output logic [CNT_W-1:0]  score_cnt_o,
   output logic [CNT_W-1:0]  near_cnt_o,
   output logic [CNT_W-1:0]  miss_cnt_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam int SUM_W = CNT_W + $clog2(LANES + 1);

   logic [1:0]       state;
   logic [DIV_W-1:0] div_cnt;
   logic [LANES-1:0] key_p1;
   logic             fetch_vld_p1;
   logic [SLOTS-1:0] shadow     [LANES];
   logic [SLOTS-1:0] shadow_nxt [LANES];
   logic [LANES-1:0] key_rise;
   logic [LANES-1:0] spawn_c;
   logic [LANES-1:0] hit_c;
   logic [LANES-1:0] near_c;
   logic [LANES-1:0] miss_c;
   logic             all_empty;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                input logic [LANES-1:0] inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(acc);
      for (int i = 0; i < LANES; i++) sum = sum + SUM_W'(inc[i]);
      if (sum > SUM_W'({CNT_W{1'b1}})) return '1;
      return sum[CNT_W-1:0];
   endfunction

   assign busy_o   = (state == S_PLAY) || (state == S_DRAIN);
   assign done_o   = (state == S_DONE);
   assign tick_o   = busy_o && (div_cnt == DIV_LAST);
   assign key_rise = key_i & ~key_p1;

   // Judgement sees the pre-shift shadow: presses clear first, then the tick shifts.
   always_comb begin
      logic [SLOTS-1:0] sh;
      sh         = '0;
      hit_c      = '0;
      near_c     = '0;
      miss_c     = '0;
      all_empty  = 1'b1;
      shadow_nxt = shadow;
      spawn_c    = (state == S_PLAY && fetch_vld_p1 && !chart_data_i[LANES]) ?
                   chart_data_i[LANES-1:0] : '0;
      for (int l = 0; l < LANES; l++) begin
         sh = shadow[l];
         if (busy_o && key_rise[l]) begin
            if (sh[0]) begin
               hit_c[l] = 1'b1;
               sh[0]    = 1'b0;
            end else if (sh[1]) begin
               near_c[l] = 1'b1;
               sh[1]     = 1'b0;
            end
         end
         if (tick_o) begin
            miss_c[l] = sh[0];
            sh        = sh >> 1;
         end
         if (spawn_c[l]) sh[SLOTS-1] = 1'b1;
         shadow_nxt[l] = sh;
         if (|sh) all_empty = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state        <= S_IDLE;
         div_cnt      <= '0;
         chart_addr_o <= '0;
         key_p1       <= '0;
         fetch_vld_p1 <= 1'b0;
         spawn_o      <= '0;
         hit_o        <= '0;
         near_o       <= '0;
         miss_o       <= '0;
         score_cnt_o  <= '0;
         near_cnt_o   <= '0;
         miss_cnt_o   <= '0;
         for (int l = 0; l < LANES; l++) shadow[l] <= '0;
      end else begin
         key_p1       <= key_i;
         // Tick stage p0 -> ROM address latched; p1 -> ROM data valid, spawn decided.
         fetch_vld_p1 <= tick_o && (state == S_PLAY);
         spawn_o      <= spawn_c;
         hit_o        <= hit_c;
         near_o       <= near_c;
         miss_o       <= miss_c;
         case (state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state        <= S_PLAY;
                  div_cnt      <= '0;
                  chart_addr_o <= '0;
                  score_cnt_o  <= '0;
                  near_cnt_o   <= '0;
                  miss_cnt_o   <= '0;
                  for (int l = 0; l < LANES; l++) shadow[l] <= '0;
               end
            end
            default: begin
               div_cnt <= tick_o ? '0 : div_cnt + 1'b1;
               for (int l = 0; l < LANES; l++) shadow[l] <= shadow_nxt[l];
               score_cnt_o <= sat_add(score_cnt_o, hit_c);
               near_cnt_o  <= sat_add(near_cnt_o, near_c);
               miss_cnt_o  <= sat_add(miss_cnt_o, miss_c);
               if (state == S_PLAY && fetch_vld_p1) begin
                  if (chart_data_i[LANES] || chart_addr_o == ADDR_LAST)
                     state <= S_DRAIN;
                  else
                     chart_addr_o <= chart_addr_o + 1'b1;
               end
               if (state == S_DRAIN && tick_o && all_empty) state <= S_DONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: note-position reference model compared every cycle,
// a table of single-note judgement cases, and hand-written timing/reset/saturation runs.
module tb_note_scheduler;
   localparam int LANES = 4;
   localparam int SLOTS = 8;
   localparam int TD    = 8;

   logic       clk = 1'b0;
   logic       RST;
   logic       start_i;
   logic [3:0] key_i;
   logic [7:0] chart_addr_o;
   logic [4:0] chart_data_i;
   logic       tick_o;
   logic [3:0] spawn_o, hit_o, near_o, miss_o;
   logic [7:0] score_cnt_o, near_cnt_o, miss_cnt_o;
   logic       busy_o, done_o;

   note_scheduler #(.LANES(LANES), .SLOTS(SLOTS), .TICK_DIV(TD), .ADDR_W(8), .CNT_W(8)) dut (
      .clk(clk), .RST(RST), .start_i(start_i), .key_i(key_i),
      .chart_addr_o(chart_addr_o), .chart_data_i(chart_data_i),
      .tick_o(tick_o), .spawn_o(spawn_o), .hit_o(hit_o), .near_o(near_o), .miss_o(miss_o),
      .score_cnt_o(score_cnt_o), .near_cnt_o(near_cnt_o), .miss_cnt_o(miss_cnt_o),
      .busy_o(busy_o), .done_o(done_o));

   always #5 clk = ~clk;

   logic [4:0] rom [256];
   always @(posedge clk) chart_data_i <= rom[chart_addr_o];

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;
   bit model_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t, cyc=%0d)", nm, act, exp, $time, cyc);
   endtask

   // Reference model: notes are (lane, position) records; position 0 is the hit zone.
   typedef struct { int lane; int pos; } note_t;
   note_t notes[$];
   int m_st, m_age, m_addr, m_faddr, m_score, m_nearc, m_missc;
   bit m_fetch;
   logic [3:0] m_kprev, m_hit, m_nearv, m_missv, m_spawn;

   function automatic int find_note(input int lane, input int pos);
      for (int i = 0; i < notes.size(); i++)
         if (notes[i].lane == lane && notes[i].pos == pos) return i;
      return -1;
   endfunction

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   always @(posedge clk) begin : model
      int old_st, old_addr, idx;
      logic [3:0] edges;
      logic [4:0] d;
      bit tk;
      note_t kept[$];
      note_t nn;
      if (RST) begin
         m_st = 0; m_age = 0; m_addr = 0; m_faddr = 0; m_fetch = 0;
         m_score = 0; m_nearc = 0; m_missc = 0; m_kprev = 0;
         m_hit = 0; m_nearv = 0; m_missv = 0; m_spawn = 0;
         notes.delete();
      end else begin
         edges = key_i & ~m_kprev;
         m_kprev = key_i;
         m_hit = 0; m_nearv = 0; m_missv = 0; m_spawn = 0;
         old_st = m_st; old_addr = m_addr;
         if (old_st == 0 || old_st == 3) begin
            if (start_i) begin
               m_st = 1; m_age = 0; m_addr = 0; m_fetch = 0;
               m_score = 0; m_nearc = 0; m_missc = 0;
               notes.delete();
            end
         end else begin
            tk = (m_age % TD) == TD - 1;
            for (int l = 0; l < LANES; l++) begin
               if (edges[l]) begin
                  idx = find_note(l, 0);
                  if (idx >= 0) begin m_hit[l] = 1'b1; notes.delete(idx); end
                  else begin
                     idx = find_note(l, 1);
                     if (idx >= 0) begin m_nearv[l] = 1'b1; notes.delete(idx); end
                  end
               end
            end
            if (tk) begin
               kept.delete();
               foreach (notes[i]) begin
                  if (notes[i].pos == 0) m_missv[notes[i].lane] = 1'b1;
                  else begin nn = notes[i]; nn.pos--; kept.push_back(nn); end
               end
               notes = kept;
            end
            if (m_fetch && old_st == 1) begin
               d = rom[m_faddr];
               if (d[4]) m_st = 2;
               else begin
                  m_spawn = d[3:0];
                  for (int l = 0; l < LANES; l++)
                     if (d[l]) begin nn.lane = l; nn.pos = SLOTS - 1; notes.push_back(nn); end
                  if (m_addr == 255) m_st = 2; else m_addr++;
               end
            end
            if (old_st == 2 && tk && notes.size() == 0) m_st = 3;
            m_fetch = tk && old_st == 1;
            m_faddr = old_addr;
            m_age++;
            m_score = sat(m_score + $countones(m_hit));
            m_nearc = sat(m_nearc + $countones(m_nearv));
            m_missc = sat(m_missc + $countones(m_missv));
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("m_tick", tick_o, ((m_st == 1 || m_st == 2) && (m_age % TD) == TD - 1));
         chk("m_spawn", spawn_o, m_spawn);
         chk("m_hit", hit_o, m_hit);
         chk("m_near", near_o, m_nearv);
         chk("m_miss", miss_o, m_missv);
         chk("m_score", score_cnt_o, m_score);
         chk("m_nearcnt", near_cnt_o, m_nearc);
         chk("m_misscnt", miss_cnt_o, m_missc);
         chk("m_addr", chart_addr_o, m_addr);
         chk("m_busy", busy_o, (m_st == 1 || m_st == 2));
         chk("m_done", done_o, (m_st == 3));
      end
   end

   task automatic nxt();
      @(negedge clk);
      cyc++;
   endtask

   // Called mid-cycle; returns mid-cycle 0 (first PLAY cycle).
   task automatic do_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 5'h10;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_tick"}, tick_o, 0);
      chk({tag, "_spawn"}, spawn_o, 0);
      chk({tag, "_hit"}, hit_o, 0);
      chk({tag, "_near"}, near_o, 0);
      chk({tag, "_miss"}, miss_o, 0);
      chk({tag, "_score"}, score_cnt_o, 0);
      chk({tag, "_nearcnt"}, near_cnt_o, 0);
      chk({tag, "_misscnt"}, miss_cnt_o, 0);
      chk({tag, "_addr"}, chart_addr_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
   endtask

   typedef struct {
      logic [3:0] mask;
      logic [3:0] keys;
      int         press;
      bit         hold;
      logic [3:0] hitv;
      logic [3:0] nearv;
      int         nh, nn, nm;
   } vec_t;

   vec_t tbl[13];

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, n_tot=%0d", n_tot);
      $fatal(1, "watchdog");
   end

   initial begin
      bit rst_hit;
      int rows, budget, rst_at;

      // Note spawned at cycle 9 sits in slot 1 over cycles 56..63 and slot 0 over 64..71.
      tbl[0]  = '{4'b0001, 4'b0001, 66, 1'b0, 4'b0001, 4'b0000, 1, 0, 0};
      tbl[1]  = '{4'b0001, 4'b0001, 60, 1'b0, 4'b0000, 4'b0001, 0, 1, 0};
      tbl[2]  = '{4'b0001, 4'b0001, 71, 1'b0, 4'b0001, 4'b0000, 1, 0, 0};
      tbl[3]  = '{4'b0001, 4'b0001, 63, 1'b0, 4'b0000, 4'b0001, 0, 1, 0};
      tbl[4]  = '{4'b0001, 4'b0001, 40, 1'b0, 4'b0000, 4'b0000, 0, 0, 1};
      tbl[5]  = '{4'b1111, 4'b1111, 65, 1'b0, 4'b1111, 4'b0000, 4, 0, 0};
      tbl[6]  = '{4'b0011, 4'b0000, 66, 1'b0, 4'b0000, 4'b0000, 0, 0, 2};
      tbl[7]  = '{4'b0101, 4'b0100, 70, 1'b0, 4'b0100, 4'b0000, 1, 0, 1};
      tbl[8]  = '{4'b0010, 4'b0001, 66, 1'b0, 4'b0000, 4'b0000, 0, 0, 1};
      tbl[9]  = '{4'b0001, 4'b0001, 55, 1'b0, 4'b0000, 4'b0000, 0, 0, 1};
      tbl[10] = '{4'b0001, 4'b0001, -1, 1'b1, 4'b0000, 4'b0000, 0, 0, 1};
      tbl[11] = '{4'b0001, 4'b0001, 64, 1'b0, 4'b0001, 4'b0000, 1, 0, 0};
      tbl[12] = '{4'b0001, 4'b0001, 56, 1'b0, 4'b0000, 4'b0001, 0, 1, 0};

      clear_rom();
      RST = 1'b1; start_i = 1'b0; key_i = 4'b0;
      @(negedge clk);
      @(negedge clk);
      model_on = 1'b1;
      chk_zero("rst");
      RST = 1'b0;
      nxt();

      // Reference chart: two notes then end marker.
      rom[0] = 5'h01; rom[1] = 5'h02; rom[2] = 5'h10;
      do_start();
      for (int c = 0; c <= 85; c++) begin
         chk("A_tick", tick_o, (c < 80 && c % 8 == 7));
         chk("A_spawn", spawn_o, (c == 9) ? 1 : (c == 17) ? 2 : 0);
         chk("A_miss", miss_o, (c == 72) ? 1 : (c == 80) ? 2 : 0);
         chk("A_done", done_o, (c >= 80));
         chk("A_busy", busy_o, (c < 80));
         if (c == 30) chk("A_addr", chart_addr_o, 2);
         if (c < 85) nxt();
      end
      chk("A_misscnt", miss_cnt_o, 2);
      chk("A_score", score_cnt_o, 0);

      foreach (tbl[t]) begin
         clear_rom();
         rom[0] = {1'b0, tbl[t].mask};
         key_i = tbl[t].hold ? tbl[t].keys : 4'b0;
         nxt();
         do_start();
         chk("T_addr0", chart_addr_o, 0);
         chk("T_score0", score_cnt_o, 0);
         chk("T_miss0", miss_cnt_o, 0);
         while (cyc < 200) begin
            if (cyc == tbl[t].press + 1) begin
               chk("T_hitv", hit_o, tbl[t].hitv);
               chk("T_nearv", near_o, tbl[t].nearv);
            end
            if (done_o) break;
            key_i = tbl[t].hold ? tbl[t].keys : ((cyc == tbl[t].press) ? tbl[t].keys : 4'b0);
            nxt();
         end
         key_i = 4'b0;
         chk("T_done", done_o, 1);
         chk("T_score", score_cnt_o, tbl[t].nh);
         chk("T_nearcnt", near_cnt_o, tbl[t].nn);
         chk("T_misscnt", miss_cnt_o, tbl[t].nm);
      end

      // start while busy is ignored; RST mid-play aborts.
      clear_rom();
      rom[0] = 5'h01; rom[1] = 5'h02;
      nxt();
      do_start();
      while (cyc < 75) begin
         start_i = (cyc == 20);
         if (cyc == 24) begin
            chk("C_addr", chart_addr_o, 2);
            chk("C_busy", busy_o, 1);
         end
         nxt();
      end
      start_i = 1'b0;
      chk("C_misscnt", miss_cnt_o, 1);
      RST = 1'b1;
      nxt();
      RST = 1'b0;
      chk_zero("C_rst");
      for (int c = 0; c < 20; c++) begin
         nxt();
         chk("C_idle_tick", tick_o, 0);
         chk("C_idle_busy", busy_o, 0);
      end

      // Saturation: 320 notes, one key edge per lane per tick once notes reach slot 0.
      clear_rom();
      for (int r = 0; r < 80; r++) rom[r] = 5'h0F;
      do_start();
      while (!done_o && cyc < 1500) begin
         key_i = (cyc >= 64 && cyc % 8 < 4) ? 4'hF : 4'h0;
         nxt();
      end
      key_i = 4'b0;
      chk("S_done", done_o, 1);
      chk("S_score", score_cnt_o, 255);
      chk("S_nearcnt", near_cnt_o, 0);
      chk("S_misscnt", miss_cnt_o, 0);

      // Random charts and key activity against the model.
      for (int it = 0; it < 6; it++) begin
         clear_rom();
         rows = $urandom_range(1, 10);
         for (int r = 0; r < rows; r++) rom[r] = {1'b0, 4'($urandom)};
         budget = rows * 8 + 120;
         rst_at = (it == 5) ? $urandom_range(10, 60) : -1;
         rst_hit = 1'b0;
         nxt();
         do_start();
         while (!done_o && cyc < budget) begin
            if (cyc == rst_at) begin
               RST = 1'b1;
               nxt();
               RST = 1'b0;
               rst_hit = 1'b1;
               break;
            end
            key_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : key_i;
            start_i = ($urandom_range(0, 40) == 0);
            nxt();
         end
         start_i = 1'b0;
         key_i = 4'b0;
         if (rst_hit) chk("R_rst_busy", busy_o, 0);
         else chk("R_done", done_o, 1);
      end

      nxt();
      nxt();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
